// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared constants and state encoding for the iterative divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 32;

  // DivAns layout for the default width: {remainder, quotient}
  localparam int REM_HI = 2 * DIV_WIDTH - 1;
  localparam int REM_LO = DIV_WIDTH;
  localparam int QUO_HI = DIV_WIDTH - 1;
  localparam int QUO_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div_unit_if.sv
// ============================================================================
// Module   : div_unit_if
// Purpose  : Start/busy/done handshake and operand/result bus of div_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface div_unit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 signed_op;
  logic                 busy;
  logic                 done;
  logic                 div_zero;
  logic [2*WIDTH-1:0]   DivAns;

  modport master (
    output start, dividend, divisor, signed_op,
    input  busy, done, div_zero, DivAns
  );

  modport slave (
    input  start, dividend, divisor, signed_op,
    output busy, done, div_zero, DivAns
  );
endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] i_rem,
  input  wire logic [WIDTH-1:0] i_quo,
  input  wire logic [WIDTH-1:0] i_divisor,
  output logic      [WIDTH-1:0] o_rem,
  output logic      [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_ge;

  // rem < divisor holds between steps, so the signed trial fits in WIDTH+1 bits
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_divisor};
  assign w_ge    = ~w_trial[WIDTH];

  assign o_rem = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle restoring divider producing {remainder, quotient}.
//            Define SIGNED_DIV_EN to add signed (MIPS DIV) support via a FIX state.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  wire logic   clk,
  input  wire logic   rst,
  div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);

  div_state_t           r_state;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dvsr;
  logic [CW-1:0]        r_count;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dz;
  logic [2*WIDTH-1:0]   r_ans;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quo_nxt;

`ifdef SIGNED_DIV_EN
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     w_fix_rem;
  logic [WIDTH-1:0]     w_fix_quo;

  assign w_a_neg   = bus.signed_op & bus.dividend[WIDTH-1];
  assign w_b_neg   = bus.signed_op & bus.divisor[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -bus.dividend : bus.dividend;
  assign w_b_mag   = w_b_neg ? -bus.divisor  : bus.divisor;
  assign w_fix_rem = r_neg_r ? -r_rem : r_rem;
  assign w_fix_quo = r_neg_q ? -r_quo : r_quo;
`else
  logic                 w_unused_signed_op;

  assign w_unused_signed_op = bus.signed_op;
  assign w_a_mag            = bus.dividend;
  assign w_b_mag            = bus.divisor;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvsr),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_ans   <= '0;
`ifdef SIGNED_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_dz <= 1'b0;
            if (bus.divisor == '0) begin
              // divide-by-zero bypasses CALC and any sign correction
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_ans   <= {bus.dividend, {WIDTH{1'b1}}};
              r_state <= ST_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_dvsr  <= w_b_mag;
              r_count <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
`ifdef SIGNED_DIV_EN
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
`endif
            end
          end
        end

        ST_CALC: begin
          r_rem   <= w_rem_nxt;
          r_quo   <= w_quo_nxt;
          r_count <= r_count + CW'(1);
          if (r_count == c_last_step) begin
`ifdef SIGNED_DIV_EN
            r_state <= ST_FIX;
`else
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ans   <= {w_rem_nxt, w_quo_nxt};
            r_state <= ST_DONE;
`endif
          end
        end

`ifdef SIGNED_DIV_EN
        ST_FIX: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_ans   <= {w_fix_rem, w_fix_quo};
          r_state <= ST_DONE;
        end
`endif

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
  assign bus.DivAns   = r_ans;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: cycle model plus directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;
`ifdef SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
  localparam int LAT       = W + 2;
`else
  localparam bit SIGNED_EN = 1'b0;
  localparam int LAT       = W + 1;
`endif

  logic clk = 1'b0;
  logic rst;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Reference arithmetic: unsigned, or truncating signed when enabled
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s && SIGNED_EN) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = int'(a);
      sb = int'(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Cycle model: an accepted op completes a fixed number of edges later
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [63:0] m_ans  = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;
  logic        cmp_en = 1'b0;

  always @(posedge clk) begin
    logic was_done;
    was_done = m_done;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_ans = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_ans = m_pend;
        end
      end else if (!was_done && bus.start) begin
        m_pend = model_div(bus.dividend, bus.divisor, bus.signed_op);
        if (bus.divisor == '0) begin
          m_dz = 1'b1; m_done = 1'b1; m_ans = m_pend;
        end else begin
          m_dz = 1'b0; m_busy = 1'b1; m_left = LAT - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc busy",     64'(bus.busy),     64'(m_busy));
      check("cyc done",     64'(bus.done),     64'(m_done));
      check("cyc div_zero", 64'(bus.div_zero), 64'(m_dz));
      check("cyc DivAns",   bus.DivAns,        m_ans);
    end
  end

  // Launch one op at a negedge; optionally pulse a stray 9/3 start at cycle N+glitch
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp_ans, input logic exp_dz,
                       input int exp_lat, input int glitch);
    int lat;
    lat = -1;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.signed_op = s;
    @(negedge clk);
    for (int k = 1; k <= 60; k++) begin
      if (k == glitch) begin
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
      end else begin
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      end
      if (k == 1 && exp_lat > 1) check({name, " busy@N+1"}, 64'(bus.busy), 64'd1);
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " DivAns"}, bus.DivAns, exp_ans);
    check({name, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    check({name, " model"}, exp_ans, model_div(a, b, s));
    @(negedge clk);
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.signed_op = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy",     64'(bus.busy),     64'd0);
    check("reset done",     64'(bus.done),     64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset DivAns",   bus.DivAns,        64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    do_op("100/7",    32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 1'b0, LAT, 0);
    do_op("max/1",    32'hFFFF_FFFF,  32'd1,          1'b0, 64'h00000000_FFFFFFFF, 1'b0, LAT, 0);
    do_op("3/max",    32'd3,          32'hFFFF_FFFF,  1'b0, 64'h00000003_00000000, 1'b0, LAT, 0);
    do_op("5/0",      32'd5,          32'd0,          1'b0, 64'h00000005_FFFFFFFF, 1'b1, 1,   0);
    do_op("busy-ign", 32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 1'b0, LAT, 5);
    do_op("b2b 9/3",  32'd9,          32'd3,          1'b0, 64'h00000000_00000003, 1'b0, LAT, 0);

    // Reset mid-operation aborts the op
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy",   64'(bus.busy), 64'd0);
    check("midrst DivAns", bus.DivAns,    64'd0);
    dones = 0;
    repeat (40) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("midrst no done", 64'(dones), 64'd0);
    do_op("8/2", 32'd8, 32'd2, 1'b0, 64'h00000000_00000004, 1'b0, LAT, 0);

`ifdef SIGNED_DIV_EN
    do_op("-7/2",     32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0, LAT, 0);
    do_op("7/-2",     32'd7,          32'hFFFF_FFFE,  1'b1, 64'h00000001_FFFFFFFD, 1'b0, LAT, 0);
    do_op("min/-1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000, 1'b0, LAT, 0);
    do_op("-5/0 s",   32'hFFFF_FFFB,  32'd0,          1'b1, 64'hFFFFFFFB_FFFFFFFF, 1'b1, 1,   0);
    do_op("-7/2 u",   32'hFFFF_FFF9,  32'd2,          1'b0, 64'h00000001_7FFFFFFC, 1'b0, LAT, 0);
`else
    do_op("s ignored", 32'hFFFF_FFF9, 32'd2,          1'b1, 64'h00000001_7FFFFFFC, 1'b0, LAT, 0);
`endif

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
